// File: rtl/wb_reg_slave_if.sv
// Wishbone classic bus bundle for the register slave.
// Suffixes follow the slave's point of view.
interface wb_reg_slave_if #(
   parameter int DW = 32,
   parameter int AW = 10
);
   logic [AW-1:0]   wb_adr_i;
   logic [DW-1:0]   wb_dat_i;
   logic [DW/8-1:0] wb_sel_i;
   logic            wb_we_i;
   logic            wb_cyc_i;
   logic            wb_stb_i;
   logic [DW-1:0]   wb_dat_o;
   logic            wb_ack_o;
   logic            wb_err_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i,
      output wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i,
      input  wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/wb_reg_slave.sv
// Wishbone register slave: interrupt source/mask pair
// plus general registers, optional wait states.
module wb_reg_slave #(
   parameter int DW          = 32,
   parameter int AW          = 10,
   parameter int NREGS       = 16,
   parameter int WAIT_STATES = 0,
   parameter int IW          = 8
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   wb_reg_slave_if.slave            bus,
   input  logic [IW-1:0]            irq_i,
   output logic                     int_o,
   output logic [(NREGS-2)*DW-1:0]  regs_o
);
   localparam int SW = DW / 8;
   localparam logic [3:0] WS_LD =
      4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t        state, state_n;
   logic [3:0]    cnt, cnt_n;

   logic [AW-1:0] adr_q;
   logic          we_q;
   logic [SW-1:0] sel_q;
   logic [DW-1:0] dat_q;

   logic [IW-1:0] int_src, int_mask;
   logic [DW-1:0] gp [2:NREGS-1];
   logic [DW-1:0] dat_r;

   logic          req, commit, wr;
   logic          c_we, c_hit, resp_hit;
   logic [AW-1:0] c_adr;
   logic [SW-1:0] c_sel;
   logic [DW-1:0] c_dat, c_mask, rdata;
   logic [IW-1:0] src_clr;

   assign req = bus.wb_cyc_i & bus.wb_stb_i;

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES > 0) begin
                  state_n = WAIT;
                  cnt_n   = WS_LD;
               end else begin
                  state_n = RESP;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == 4'd0) begin
               state_n = RESP;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         adr_q <= '0;
         we_q  <= 1'b0;
         sel_q <= '0;
         dat_q <= '0;
      end else if (state == IDLE && req) begin
         adr_q <= bus.wb_adr_i;
         we_q  <= bus.wb_we_i;
         sel_q <= bus.wb_sel_i;
         dat_q <= bus.wb_dat_i;
      end
   end

   // With no wait states the commit edge is the accept edge,
   // so the live bus is used instead of the captured copy.
   assign c_adr = (state == IDLE) ? bus.wb_adr_i : adr_q;
   assign c_we  = (state == IDLE) ? bus.wb_we_i  : we_q;
   assign c_sel = (state == IDLE) ? bus.wb_sel_i : sel_q;
   assign c_dat = (state == IDLE) ? bus.wb_dat_i : dat_q;

   assign c_hit    = {1'b0, c_adr} < (AW+1)'(NREGS);
   assign resp_hit = {1'b0, adr_q} < (AW+1)'(NREGS);
   assign commit   = (state_n == RESP) && (state != RESP);
   assign wr       = commit & c_we & c_hit;

   always_comb begin
      c_mask = '0;
      for (int b = 0; b < SW; b++)
         c_mask[b*8 +: 8] = {8{c_sel[b]}};
   end

   always_comb begin
      rdata = '0;
      if (c_adr == AW'(0))
         rdata = DW'(int_src);
      else if (c_adr == AW'(1))
         rdata = DW'(int_mask);
      for (int i = 2; i < NREGS; i++)
         if (c_adr == AW'(i))
            rdata = gp[i];
   end

   assign src_clr = (wr && c_adr == AW'(0)) ?
                    (c_dat[IW-1:0] & c_mask[IW-1:0]) : '0;

   // Sources OR in after the clear so a same-edge set wins.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         int_src  <= '0;
         int_mask <= '0;
         int_o    <= 1'b0;
      end else begin
         int_src <= (int_src & ~src_clr) | irq_i;
         if (wr && c_adr == AW'(1))
            int_mask <= (int_mask & ~c_mask[IW-1:0])
                      | (c_dat[IW-1:0] & c_mask[IW-1:0]);
         int_o <= |(int_src & int_mask);
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         for (int i = 2; i < NREGS; i++)
            gp[i] <= '0;
      end else begin
         for (int i = 2; i < NREGS; i++)
            if (wr && c_adr == AW'(i))
               gp[i] <= (gp[i] & ~c_mask) | (c_dat & c_mask);
      end
   end

   // Read data is taken from pre-edge register values.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i)
         dat_r <= '0;
      else
         dat_r <= (commit && c_hit) ? rdata : '0;
   end

   assign bus.wb_dat_o = dat_r;
   assign bus.wb_ack_o = (state == RESP) &  resp_hit;
   assign bus.wb_err_o = (state == RESP) & ~resp_hit;

   always_comb begin
      regs_o = '0;
      for (int i = 2; i < NREGS; i++)
         regs_o[(i-2)*DW +: DW] = gp[i];
   end
endmodule

// File: tb/tb_wb_reg_slave.sv
// Bench for wb_reg_slave: one zero-wait and one
// three-wait instance against a register-map model.
module tb_wb_reg_slave;
   localparam int RW = (16 - 2) * 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  adr = '0;
   logic [31:0] wdat = '0;
   logic [3:0]  sel = '0;
   logic        we = 1'b0;
   logic [1:0]  cyc = '0;
   logic [1:0]  stb = '0;
   logic [7:0]  irq = '0;

   logic [1:0]  ack, err, into;
   logic [31:0] dat [2];
   logic [RW-1:0] rg [2];

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [2][16];
   logic [31:0] last_rd;
   bit          last_io;

   always #5 clk = ~clk;

   wb_reg_slave_if #(.DW(32), .AW(10)) b0 ();
   wb_reg_slave_if #(.DW(32), .AW(10)) b3 ();

   assign b0.wb_adr_i = adr;
   assign b0.wb_dat_i = wdat;
   assign b0.wb_sel_i = sel;
   assign b0.wb_we_i  = we;
   assign b0.wb_cyc_i = cyc[0];
   assign b0.wb_stb_i = stb[0];
   assign b3.wb_adr_i = adr;
   assign b3.wb_dat_i = wdat;
   assign b3.wb_sel_i = sel;
   assign b3.wb_we_i  = we;
   assign b3.wb_cyc_i = cyc[1];
   assign b3.wb_stb_i = stb[1];

   assign ack[0] = b0.wb_ack_o;
   assign err[0] = b0.wb_err_o;
   assign dat[0] = b0.wb_dat_o;
   assign ack[1] = b3.wb_ack_o;
   assign err[1] = b3.wb_err_o;
   assign dat[1] = b3.wb_dat_o;

   wb_reg_slave #(
      .DW(32), .AW(10), .NREGS(16), .WAIT_STATES(0), .IW(8)
   ) dut0 (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .bus      (b0),
      .irq_i    (irq),
      .int_o    (into[0]),
      .regs_o   (rg[0])
   );

   wb_reg_slave #(
      .DW(32), .AW(10), .NREGS(16), .WAIT_STATES(3), .IW(8)
   ) dut3 (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .bus      (b3),
      .irq_i    (irq),
      .int_o    (into[1]),
      .regs_o   (rg[1])
   );

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++)
            mem[d][i] = '0;
   endtask

   // Register-map model: returns pre-access value, applies
   // the lane-masked write, then the irq set (set wins).
   task automatic mdl(input int d, input bit w, input int idx,
                      input logic [31:0] wd,
                      input logic [3:0] sl,
                      input logic [7:0] iv,
                      output logic [31:0] erd,
                      output bit eerr);
      logic [31:0] bm;
      for (int b = 0; b < 4; b++)
         bm[b*8 +: 8] = {8{sl[b]}};
      eerr = (idx >= 16);
      erd  = eerr ? 32'h0 : mem[d][idx];
      if (!eerr && w) begin
         if (idx == 0)
            mem[d][0] = mem[d][0] & ~(wd & bm);
         else if (idx == 1)
            mem[d][1] = ((mem[d][1] & ~bm) | (wd & bm))
                      & 32'hFF;
         else
            mem[d][idx] = (mem[d][idx] & ~bm) | (wd & bm);
      end
      for (int k = 0; k < 2; k++)
         mem[k][0] = mem[k][0] | {24'h0, iv};
   endtask

   task automatic xfer(input int d, input bit w, input int idx,
                       input logic [31:0] wd,
                       input logic [3:0] sl,
                       input logic [7:0] iv,
                       output logic [31:0] rd,
                       output bit a, output bit e,
                       output int n, output bit io);
      adr    = 10'(idx);
      we     = w;
      wdat   = wd;
      sel    = sl;
      irq    = iv;
      cyc[d] = 1'b1;
      stb[d] = 1'b1;
      @(posedge clk);
      #1 irq = '0;
      n  = 0;
      a  = 1'b0;
      e  = 1'b0;
      rd = '0;
      io = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         n++;
         if (ack[d] | err[d]) begin
            a  = ack[d];
            e  = err[d];
            rd = dat[d];
            io = into[d];
            break;
         end
      end
      if (!(a | e))
         n = 99;
      @(posedge clk);
      #1;
      cyc[d] = 1'b0;
      stb[d] = 1'b0;
   endtask

   task automatic acc(input int d, input bit w, input int idx,
                      input logic [31:0] wd,
                      input logic [3:0] sl,
                      input logic [7:0] iv);
      logic [31:0] erd, rd;
      bit eerr, a, e, io;
      int n;
      string t;
      t = $sformatf("d%0d_%s_%0d", d, w ? "wr" : "rd", idx);
      mdl(d, w, idx, wd, sl, iv, erd, eerr);
      xfer(d, w, idx, wd, sl, iv, rd, a, e, n, io);
      chk({t, "_ack"}, 64'(a), 64'(!eerr));
      chk({t, "_err"}, 64'(e), 64'(eerr));
      chk({t, "_lat"}, 64'(n), (d == 0) ? 64'd1 : 64'd4);
      if (!w || eerr)
         chk({t, "_dat"}, 64'(rd), 64'(erd));
      last_rd = rd;
      last_io = io;
   endtask

   task automatic chk_regs();
      for (int d = 0; d < 2; d++)
         for (int i = 2; i < 16; i++)
            chk($sformatf("d%0d_regs_o_%0d", d, i),
                64'(rg[d][(i-2)*32 +: 32]), 64'(mem[d][i]));
   endtask

   initial begin
      bit seen;
      mdl_reset();

      #3;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_ack%0d", d), 64'(ack[d]), 64'd0);
         chk($sformatf("rst_err%0d", d), 64'(err[d]), 64'd0);
         chk($sformatf("rst_dat%0d", d), 64'(dat[d]), 64'd0);
         chk($sformatf("rst_int%0d", d), 64'(into[d]), 64'd0);
         chk($sformatf("rst_regs%0d", d),
             64'(|rg[d]), 64'd0);
      end

      @(negedge clk);
      #2 rst_n = 1'b1;

      acc(0, 1'b1, 2, 32'hDEADBEEF, 4'hF, 8'h0);
      acc(0, 1'b0, 2, 32'h0, 4'hF, 8'h0);
      chk("deadbeef_rd", 64'(last_rd), 64'hDEADBEEF);
      chk("deadbeef_regs_o", 64'(rg[0][31:0]), 64'hDEADBEEF);

      acc(0, 1'b1, 3, 32'h0, 4'hF, 8'h0);
      acc(0, 1'b1, 3, 32'hAABBCCDD, 4'h5, 8'h0);
      acc(0, 1'b0, 3, 32'h0, 4'hF, 8'h0);
      chk("lane_rd", 64'(last_rd), 64'h00BB00DD);

      acc(0, 1'b0, 16, 32'h0, 4'hF, 8'h0);
      acc(0, 1'b1, 16, 32'h12345678, 4'hF, 8'h0);
      chk_regs();

      acc(1, 1'b1, 4, 32'hCAFEF00D, 4'hF, 8'h0);
      acc(1, 1'b0, 4, 32'h0, 4'hF, 8'h0);

      adr    = 10'd4;
      we     = 1'b1;
      wdat   = 32'h0BADC0DE;
      sel    = 4'hF;
      cyc[1] = 1'b1;
      stb[1] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      cyc[1] = 1'b0;
      stb[1] = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen = seen | ack[1] | err[1];
      end
      chk("abort_no_resp", 64'(seen), 64'd0);
      acc(1, 1'b0, 4, 32'h0, 4'hF, 8'h0);
      chk("abort_unchanged", 64'(last_rd), 64'hCAFEF00D);

      for (int k = 0; k < 40; k++)
         acc(int'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             int'($urandom_range(0, 17)),
             32'($urandom),
             4'($urandom_range(0, 15)),
             8'h0);
      chk_regs();

      acc(0, 1'b1, 1, 32'h1, 4'hF, 8'h0);
      acc(0, 1'b1, 0, 32'hFF, 4'hF, 8'h0);
      @(negedge clk);
      chk("int_idle", 64'(into[0]), 64'd0);

      @(posedge clk);
      #1 irq = 8'h01;
      @(posedge clk);
      #1 irq = 8'h00;
      mem[0][0] = mem[0][0] | 32'h1;
      mem[1][0] = mem[1][0] | 32'h1;
      @(negedge clk);
      chk("int_lat0", 64'(into[0]), 64'd0);
      @(negedge clk);
      chk("int_lat1", 64'(into[0]), 64'd1);

      acc(0, 1'b1, 0, 32'h1, 4'hF, 8'h01);
      acc(0, 1'b0, 0, 32'h0, 4'hF, 8'h0);
      chk("set_wins_src", 64'(last_rd), 64'h1);
      chk("set_wins_int", 64'(into[0]), 64'd1);

      acc(0, 1'b1, 0, 32'h1, 4'hF, 8'h0);
      chk("clr_int_at_ack", 64'(last_io), 64'd1);
      @(negedge clk);
      chk("clr_int_after", 64'(into[0]), 64'd0);

      acc(0, 1'b0, 0, 32'h0, 4'hF, 8'h01);
      chk("src_pre_edge", 64'(last_rd), 64'h0);
      acc(0, 1'b0, 0, 32'h0, 4'hF, 8'h0);
      chk("src_post_edge", 64'(last_rd), 64'h1);

      acc(1, 1'b1, 1, 32'h1, 4'hF, 8'h0);
      acc(1, 1'b1, 2, 32'h55AA55AA, 4'hF, 8'h0);
      @(negedge clk);
      chk("d1_int_before_rst", 64'(into[1]), 64'd1);

      adr    = 10'd2;
      we     = 1'b0;
      cyc[1] = 1'b1;
      stb[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("arst_ack%0d", d), 64'(ack[d]), 64'd0);
         chk($sformatf("arst_err%0d", d), 64'(err[d]), 64'd0);
         chk($sformatf("arst_dat%0d", d), 64'(dat[d]), 64'd0);
         chk($sformatf("arst_int%0d", d), 64'(into[d]), 64'd0);
         chk($sformatf("arst_regs%0d", d),
             64'(|rg[d]), 64'd0);
      end
      cyc[1] = 1'b0;
      stb[1] = 1'b0;
      mdl_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | ack[1] | err[1];
      end
      chk("rst_no_resp", 64'(seen), 64'd0);

      acc(1, 1'b1, 5, 32'h13579BDF, 4'hF, 8'h0);
      acc(1, 1'b0, 5, 32'h0, 4'hF, 8'h0);
      chk("post_rst_rd", 64'(last_rd), 64'h13579BDF);
      chk_regs();

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
